// File: rtl/cic_gain_sched_pkg.sv
// Shared widths, state encodings and default thresholds for the CIC gain scheduler.
// Also holds the gain clamp and saturating magnitude helpers.
package cic_gain_sched_pkg;
  localparam int GAIN_W = 8;
  localparam int SAMP_W = 32;

  localparam logic [SAMP_W-1:0] DEF_HI_THRESH   = 32'h4000_0000;
  localparam logic [SAMP_W-1:0] DEF_LO_THRESH   = 32'h0800_0000;
  localparam logic [SAMP_W-1:0] DEF_CLIP_THRESH = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND_I, OUT_SEND_Q} out_st_t;
  typedef enum logic {AGC_TRACK, AGC_HOLD} agc_st_t;

  function automatic logic [GAIN_W-1:0] clamp_gain(input int g, input int lo, input int hi);
    if (g < lo) return GAIN_W'(lo);
    if (g > hi) return GAIN_W'(hi);
    return GAIN_W'(g);
  endfunction

  // -2**31 has no positive twin, so it saturates to the largest positive code
  function automatic logic [SAMP_W-1:0] abs_sat(input logic [SAMP_W-1:0] x);
    if (x == {1'b1, {(SAMP_W-1){1'b0}}}) return {1'b0, {(SAMP_W-1){1'b1}}};
    if (x[SAMP_W-1]) return -x;
    return x;
  endfunction
endpackage

// File: rtl/cic_gain_sched_if.sv
// Serialized I/Q sample stream with valid/ready handshake.
interface cic_gain_sched_if;
  import cic_gain_sched_pkg::*;
  logic [SAMP_W-1:0] out_data;
  logic              out_is_q;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, out_is_q, out_valid, input out_ready);
  modport slave  (input out_data, out_is_q, out_valid, output out_ready);
endinterface

// File: rtl/cic_gain_sched_peak_det.sv
// Per-strobe max(|I|,|Q|) with clip detect, plus the windowed peak hold and window counter.
module cic_gain_sched_peak_det
  import cic_gain_sched_pkg::*;
#(
  parameter int                WINDOW      = 64,
  parameter logic [SAMP_W-1:0] CLIP_THRESH = DEF_CLIP_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              stb,
  input  logic [SAMP_W-1:0] i_in,
  input  logic [SAMP_W-1:0] q_in,
  output logic              clip,
  output logic              win_end,
  output logic [SAMP_W-1:0] peak
);
  localparam int CW = $clog2(WINDOW);

  logic [CW-1:0]     cnt;
  logic [SAMP_W-1:0] peak_q, mag_i, mag_q, m;

  assign mag_i = abs_sat(i_in);
  assign mag_q = abs_sat(q_in);
  assign m     = (mag_i > mag_q) ? mag_i : mag_q;
  assign clip  = stb && (m >= CLIP_THRESH);
  // peak already includes the current sample so the window decision sees it
  assign peak    = (m > peak_q) ? m : peak_q;
  assign win_end = stb && !clip && (cnt == CW'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      peak_q <= '0;
    end else if (stb) begin
      if (clip || win_end) begin
        cnt    <= '0;
        peak_q <= '0;
      end else begin
        cnt    <= cnt + 1'b1;
        peak_q <= peak;
      end
    end
  end
endmodule

// File: rtl/cic_gain_sched.sv
// AGC gain scheduler and I-then-Q output serializer for the CIC decimator pair.
module cic_gain_sched
  import cic_gain_sched_pkg::*;
#(
  parameter int                GAIN_MIN      = 0,
  parameter int                GAIN_MAX      = 48,
  parameter int                GAIN_INIT     = 16,
  parameter logic [SAMP_W-1:0] HI_THRESH     = DEF_HI_THRESH,
  parameter logic [SAMP_W-1:0] LO_THRESH     = DEF_LO_THRESH,
  parameter logic [SAMP_W-1:0] CLIP_THRESH   = DEF_CLIP_THRESH,
  parameter int                WINDOW        = 64,
  parameter int                DECAY_WINDOWS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SAMP_W-1:0] i_in,
  input  logic [SAMP_W-1:0] q_in,
  input  logic              d_stb,
  input  logic              agc_en,
  input  logic [GAIN_W-1:0] man_gain,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_chg,
  output logic              drop,
  cic_gain_sched_if.master  stream
);
  localparam int HW = $clog2(DECAY_WINDOWS + 1);

  logic              clip, win_end;
  logic [SAMP_W-1:0] peak, q_lat;
  logic [GAIN_W-1:0] gain_nxt, man_clamp;
  logic [HW-1:0]     hold, hold_nxt;
  agc_st_t           agc_st, agc_nxt;
  out_st_t           out_st;

  cic_gain_sched_peak_det #(.WINDOW(WINDOW), .CLIP_THRESH(CLIP_THRESH)) u_peak (
    .clk(clk), .rst(rst), .clr(!agc_en), .stb(d_stb),
    .i_in(i_in), .q_in(q_in),
    .clip(clip), .win_end(win_end), .peak(peak)
  );

  assign man_clamp = clamp_gain(int'(man_gain), GAIN_MIN, GAIN_MAX);

  always_comb begin
    gain_nxt = gain;
    hold_nxt = hold;
    agc_nxt  = agc_st;
    if (clip) begin
      gain_nxt = clamp_gain(int'(gain) - 2, GAIN_MIN, GAIN_MAX);
      hold_nxt = '0;
      agc_nxt  = AGC_TRACK;
    end else if (win_end) begin
      if (peak >= HI_THRESH) begin
        gain_nxt = clamp_gain(int'(gain) - 1, GAIN_MIN, GAIN_MAX);
        hold_nxt = '0;
        agc_nxt  = AGC_TRACK;
      end else if (peak < LO_THRESH) begin
        agc_nxt = AGC_HOLD;
        if (int'(hold) + 1 == DECAY_WINDOWS) begin
          gain_nxt = clamp_gain(int'(gain) + 1, GAIN_MIN, GAIN_MAX);
          hold_nxt = '0;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end else begin
        hold_nxt = '0;
        agc_nxt  = AGC_TRACK;
      end
    end
  end

  // Manual mode parks the AGC in TRACK with hold=0 so re-enable starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      gain     <= GAIN_W'(GAIN_INIT);
      gain_chg <= 1'b0;
      hold     <= '0;
      agc_st   <= AGC_TRACK;
    end else if (!agc_en) begin
      gain     <= man_clamp;
      gain_chg <= (man_clamp != gain);
      hold     <= '0;
      agc_st   <= AGC_TRACK;
    end else begin
      gain     <= gain_nxt;
      gain_chg <= (gain_nxt != gain);
      hold     <= hold_nxt;
      agc_st   <= agc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_st           <= OUT_IDLE;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_is_q  <= 1'b0;
      q_lat            <= '0;
      drop             <= 1'b0;
    end else begin
      case (out_st)
        OUT_IDLE: if (d_stb) begin
          q_lat            <= q_in;
          stream.out_data  <= i_in;
          stream.out_is_q  <= 1'b0;
          stream.out_valid <= 1'b1;
          out_st           <= OUT_SEND_I;
        end
        OUT_SEND_I: begin
          if (d_stb) drop <= 1'b1;
          if (stream.out_ready) begin
            stream.out_data <= q_lat;
            stream.out_is_q <= 1'b1;
            out_st          <= OUT_SEND_Q;
          end
        end
        OUT_SEND_Q: begin
          // a strobe landing on the Q handshake slot chains straight into the next pair
          if (stream.out_ready) begin
            if (d_stb) begin
              q_lat           <= q_in;
              stream.out_data <= i_in;
              stream.out_is_q <= 1'b0;
              out_st          <= OUT_SEND_I;
            end else begin
              stream.out_valid <= 1'b0;
              out_st           <= OUT_IDLE;
            end
          end else if (d_stb) begin
            drop <= 1'b1;
          end
        end
        default: out_st <= OUT_IDLE;
      endcase
    end
  end
endmodule
